square_iterative: RTL and testbench

- Multi-cycle unsigned squarer: takes a root and returns root*root, the inverse of the pipelined square-root block.
- Used to reconstruct or verify radicands produced by the square-root datapath, and as a compact squarer where area matters more than throughput.
- Shift-and-add, one multiplier bit per cycle, ready/valid handshake on both sides.

---
 rtl/square_iterative.sv | 107 ++++++++++
 tb/tb_square_iterative.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/square_iterative.sv
// Multi-cycle unsigned squarer (shift-and-add, one multiplier bit per cycle).
// Optional SQUARE_ITERATIVE_REMAINDER_EN adds a remainder port: square = root*root + remainder.
module square_iterative #(
  parameter int WIDTH_INPUT  = 8,
  parameter int WIDTH_OUTPUT = 2 * WIDTH_INPUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH_INPUT-1:0]    root,
`ifdef SQUARE_ITERATIVE_REMAINDER_EN
  input  logic [WIDTH_INPUT:0]      remainder,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH_OUTPUT-1:0]   square
);

  localparam int CNT_W = (WIDTH_INPUT > 1) ? $clog2(WIDTH_INPUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_INPUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic                    started;
  logic [WIDTH_OUTPUT-1:0] mcand;
  logic [WIDTH_OUTPUT-1:0] acc;
  logic [WIDTH_OUTPUT-1:0] acc_sum;
  logic [WIDTH_OUTPUT-1:0] acc_init;
  logic [WIDTH_OUTPUT-1:0] square_q;
  logic [WIDTH_INPUT-1:0]  mplier;
  logic [CNT_W-1:0]        count;
  logic                    accept;
  logic                    last_step;

  // in_ready stays low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = started;
        if (in_valid && started) state_nxt = BUSY;
      end
      BUSY: begin
        if (count == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign last_step = (state == BUSY) && (count == CNT_LAST);
  assign acc_sum   = acc + (mplier[0] ? mcand : '0);

`ifdef SQUARE_ITERATIVE_REMAINDER_EN
  assign acc_init = WIDTH_OUTPUT'(remainder);
`else
  assign acc_init = '0;
`endif

  // Datapath: the result register is loaded only on the final step, so square
  // keeps the previous result while a new operand is being worked on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      square_q <= '0;
    end else if (accept) begin
      mcand  <= WIDTH_OUTPUT'(root);
      mplier <= root;
      acc    <= acc_init;
      count  <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (last_step) square_q <= acc_sum;
    end
  end

  assign square = square_q;

endmodule

// File: tb/tb_square_iterative.sv
// Self-checking bench for square_iterative: vector table, hand-written corner sequences, random ops.
module tb_square_iterative;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   root;
  logic [W:0]     remainder;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] square;

  int vectors    = 0;
  int miscompares = 0;

  square_iterative #(.WIDTH_INPUT(W), .WIDTH_OUTPUT(2*W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .root      (root),
`ifdef SQUARE_ITERATIVE_REMAINDER_EN
    .remainder (remainder),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .square    (square)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   r;
    logic [W:0]     rem;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: the square plus remainder, reduced to the output width.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] r, input logic [W:0] rem);
    longint v;
    v = longint'(r) * longint'(r);
`ifdef SQUARE_ITERATIVE_REMAINDER_EN
    v = v + longint'(rem);
`endif
    return v[2*W-1:0];
  endfunction

  task automatic do_op(input logic [W-1:0] r, input logic [W:0] rem, input logic [2*W-1:0] exp,
                       input int hold, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    check({tag, " in_ready_before"}, in_ready, 1);
    root = r;
    remainder = rem;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check({tag, " in_ready_busy"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 50) begin tick; n++; end
    check({tag, " latency"}, n, W);
    check({tag, " square"}, square, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      root = 8'd99;
      tick;
      check({tag, " hold_valid"}, out_valid, 1);
      check({tag, " hold_square"}, square, exp);
      check({tag, " hold_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, " out_valid_drop"}, out_valid, 0);
    check({tag, " in_ready_after"}, in_ready, 1);
    check({tag, " square_kept"}, square, exp);
  endtask

  initial begin
    int n;
    logic [W-1:0] r;
    logic [W:0]   rem;

    vecs.push_back('{r: 8'd13,  rem: 9'd0, exp: 16'd169});
    vecs.push_back('{r: 8'd0,   rem: 9'd0, exp: 16'd0});
    vecs.push_back('{r: 8'd255, rem: 9'd0, exp: 16'd65025});
    vecs.push_back('{r: 8'd128, rem: 9'd0, exp: 16'd16384});
    vecs.push_back('{r: 8'd1,   rem: 9'd0, exp: 16'd1});
`ifdef SQUARE_ITERATIVE_REMAINDER_EN
    vecs.push_back('{r: 8'd255, rem: 9'd510, exp: 16'd65535});
    vecs.push_back('{r: 8'd13,  rem: 9'd5,   exp: 16'd174});
    vecs.push_back('{r: 8'd0,   rem: 9'd0,   exp: 16'd0});
`endif

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    root = '0;
    remainder = '0;
    repeat (3) tick;
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset square", square, 0);
    rst_n = 1'b1;
    tick;
    check("post_reset in_ready", in_ready, 1);
    check("post_reset out_valid", out_valid, 0);
    check("post_reset square", square, 0);

    foreach (vecs[i]) do_op(vecs[i].r, vecs[i].rem, vecs[i].exp, 0, $sformatf("vec%0d", i));

    // Back-pressure in DONE, with an ignored in_valid during the stall.
    do_op(8'd13, 9'd0, model(8'd13, 9'd0), 5, "stall");

    // Abort mid-BUSY with reset.
    root = 8'd200;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort in_ready", in_ready, 0);
    check("abort square", square, 0);
    repeat (2) tick;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (out_valid) n++;
    end
    check("abort no_out_valid", n, 0);
    do_op(8'd7, 9'd0, model(8'd7, 9'd0), 0, "after_abort");

    for (int i = 0; i < 30; i++) begin
      r = W'($urandom);
      rem = '0;
`ifdef SQUARE_ITERATIVE_REMAINDER_EN
      rem = (W+1)'($urandom_range(0, 2 * int'(r)));
`endif
      do_op(r, rem, model(r, rem), int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
